rr_arb_onehot: RTL and testbench
================================

// Module: rr_arb_onehot
// PURPOSE
//  Round-robin arbiter producing a registered one-hot grant vector.
//  Sits directly upstream of onehot_to_bin: gnt_o feeds onehot_i, and the
//  binary index selects the winning requester's payload in the datapath mux.
//  Grant held under a valid/ready handshake until the consumer accepts it.
// PARAMETERS
//  NUM_REQ   8                      number of requesters (>=2, power of 2 not required)
//  IDX_W     $clog2(NUM_REQ)        width of binary index (derived, do not override)
// PORTS
//  clk_i         in   1        clock, rising edge
//  rst_ni        in   1        asynchronous active-low reset
//  req_i         in   NUM_REQ  request vector, bit k = requester k
//  gnt_o         out  NUM_REQ  registered grant; $onehot when gnt_valid_o, else 0
//  gnt_valid_o   out  1        grant valid
//  gnt_ready_i   in   1        consumer accepts grant (handshake = valid & ready)
//  gnt_idx_o     out  IDX_W    binary index of grant (only with RR_ARB_IDX_EN)
// BEHAVIOUR
//  - Reset (async, rst_ni=0): gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, state=IDLE,
//    priority pointer ptr=0 (requester 0 highest priority).
//  - Pick: masked = req_i & ~((1<<ptr)-1); if |masked pick lowest set bit of
//    masked, else lowest set bit of req_i. Purely combinational.
//  - FSM IDLE: if |req_i -> next cycle gnt_o=pick, gnt_valid_o=1, go GRANT.
//    Latency req->grant = 1 cycle. No req -> stay IDLE, outputs 0.
//  - FSM GRANT: gnt_o, gnt_idx_o held stable while !gnt_ready_i, even if the
//    granted req bit drops (grant is sticky; no withdrawal).
//  - Handshake (valid&ready): ptr <= (granted_idx+1) mod NUM_REQ; same cycle
//    re-pick using updated ptr and current req_i excluding nothing else:
//    any req -> load new grant next cycle (back-to-back, no bubble), stay GRANT;
//    none -> gnt_o=0, gnt_valid_o=0, go IDLE.
//  - Wrap: grant at NUM_REQ-1 -> ptr=0.
//  - Single persistent requester k: re-granted every handshake.
//  - ptr only changes on handshake; requests arriving mid-grant never preempt.
//  - Reset mid-grant: grant dropped immediately, ptr back to 0.
//  - Invariant: $onehot0(gnt_o) every cycle; gnt_valid_o == |gnt_o.
// CONFIGURATION
//  RR_ARB_IDX_EN defined: gnt_idx_o port present, registered alongside gnt_o
//    (same cycle, index of set bit; 0 when invalid). Lets downstream skip a
//    separate onehot-to-binary stage.
//  RR_ARB_IDX_EN undefined: port absent; only gnt_o/gnt_valid_o produced.
// STRUCTURE
//  - Package rr_arb_pkg: typedef enum logic {IDLE, GRANT} rr_state_e;
//    function lowest_set_idx(); localparam helpers for IDX_W.
//  - Sub-module rr_prio_pick: combinational masked/unmasked lowest-bit picker
//    (inputs req, ptr; outputs one-hot pick, pick_idx, any). Top holds FSM,
//    ptr register, grant registers.
// TESTING (NUM_REQ=8)
//  1. Reset: rst_ni=0 with req_i=8'hFF -> gnt_o=0, gnt_valid_o=0; release ->
//     next cycle gnt_o=8'b0000_0001.
//  2. req_i=8'hFF, gnt_ready_i=1 constant -> gnt_o cycles 01,02,04..80,01
//     one per clock, no bubbles.
//  3. req_i=8'b1000_0100, ready=1 -> grants alternate 04,80,04,80 (fairness).
//  4. Grant 8'h04 with ready=0 for 5 cycles, req_i changed to 8'h01 ->
//     gnt_o stays 04; on ready=1 -> next gnt_o=01, ptr wraps past idx 7 logic.
//  5. Single req 8'h80 handshaken -> ptr=0; then req 8'h81 -> grant 01 first.
//  6. Assert rst_ni=0 mid-grant (gnt_o=08) -> outputs 0 same time; release
//     with req 8'h08 -> gnt_o=08 one cycle later. With RR_ARB_IDX_EN check
//     gnt_idx_o==3 throughout; assert $onehot0(gnt_o) all tests.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
package rr_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} rr_state_e;

  localparam int MAX_REQ = 64;

  // Index width never collapses to zero, even for two requesters.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int lowest_set_idx(input logic [MAX_REQ-1:0] v);
    int res;
    res = 0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (v[i]) res = i;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker: lowest request at or above ptr, else lowest overall.
module rr_prio_pick
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IDX_W-1:0]   pick_idx_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_masked;
  logic [NUM_REQ-1:0] w_src;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign w_mask[gi] = (ptr_i <= IDX_W'(gi));
  end

  assign w_masked = req_i & w_mask;
  // Fall back to the unmasked vector when nothing remains above the pointer.
  assign w_src      = (|w_masked) ? w_masked : req_i;
  assign pick_o     = w_src & (~w_src + 1'b1);
  assign pick_idx_o = IDX_W'(lowest_set_idx(MAX_REQ'(w_src)));
  assign any_o      = |req_i;

endmodule

// File: rtl/rr_arb_onehot.sv
// Round-robin arbiter with a registered one-hot grant held under valid/ready.
// Define RR_ARB_IDX_EN to also expose the registered binary grant index.
module rr_arb_onehot
  import rr_arb_pkg::*;
#(
  parameter  int NUM_REQ = 8,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  input  logic               gnt_ready_i
`ifdef RR_ARB_IDX_EN
  ,output logic [IDX_W-1:0]  gnt_idx_o
`endif
);

  rr_state_e          r_state, w_state_next;
  logic [IDX_W-1:0]   r_ptr, w_ptr_next;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
  logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_next;

  logic               w_hs;
  logic [IDX_W-1:0]   w_ptr_inc;
  logic [IDX_W-1:0]   w_pick_ptr;
  logic [NUM_REQ-1:0] w_pick;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_any;

  assign w_hs      = (r_state == GRANT) && gnt_ready_i;
  assign w_ptr_inc = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
  // On a handshake the re-pick already sees the advanced pointer, giving back-to-back grants.
  assign w_pick_ptr = w_hs ? w_ptr_inc : r_ptr;

  rr_prio_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i      (req_i),
    .ptr_i      (w_pick_ptr),
    .pick_o     (w_pick),
    .pick_idx_o (w_pick_idx),
    .any_o      (w_any)
  );

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_gnt_next     = r_gnt;
    w_gnt_idx_next = r_gnt_idx;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next   = GRANT;
          w_gnt_next     = w_pick;
          w_gnt_idx_next = w_pick_idx;
        end
      end
      GRANT: begin
        if (w_hs) begin
          w_ptr_next = w_ptr_inc;
          if (w_any) begin
            w_gnt_next     = w_pick;
            w_gnt_idx_next = w_pick_idx;
          end else begin
            w_state_next   = IDLE;
            w_gnt_next     = '0;
            w_gnt_idx_next = '0;
          end
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_gnt_next     = '0;
        w_gnt_idx_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_gnt     <= w_gnt_next;
      r_gnt_idx <= w_gnt_idx_next;
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_valid_o = (r_state == GRANT);
`ifdef RR_ARB_IDX_EN
  assign gnt_idx_o   = r_gnt_idx;
`endif

endmodule

// File: tb/tb_rr_arb_onehot.sv
// Bench for rr_arb_onehot: directed scenarios plus random traffic against a rotating-search model.
module tb_rr_arb_onehot;

  localparam int N = 8;

  logic         clk_i;
  logic         rst_ni;
  logic [N-1:0] req_i;
  logic [N-1:0] gnt_o;
  logic         gnt_valid_o;
  logic         gnt_ready_i;
`ifdef RR_ARB_IDX_EN
  logic [2:0]   gnt_idx_o;
`endif

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  int m_g   = -1;
  int step_no = 0;

  rr_arb_onehot #(.NUM_REQ(N)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_ready_i (gnt_ready_i)
`ifdef RR_ARB_IDX_EN
    ,.gnt_idx_o  (gnt_idx_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // First requester found walking upward from ptr with wrap-around; -1 if none.
  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] req, input logic rdy);
    if (m_g < 0) begin
      m_g = model_pick(req, m_ptr);
    end else if (rdy) begin
      m_ptr = (m_g + 1) % N;
      m_g   = model_pick(req, m_ptr);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] e_gnt;
    logic [N-1:0] one;
    one   = 1;
    e_gnt = (m_g >= 0) ? (one << m_g) : '0;
    chk({tag, "_gnt"}, 32'(gnt_o), 32'(e_gnt));
    chk({tag, "_valid"}, 32'(gnt_valid_o), 32'(m_g >= 0));
    chk({tag, "_onehot0"}, 32'($onehot0(gnt_o)), 32'd1);
`ifdef RR_ARB_IDX_EN
    chk({tag, "_idx"}, 32'(gnt_idx_o), (m_g >= 0) ? 32'(m_g) : 32'd0);
`endif
  endtask

  task automatic step(input string tag, input logic [N-1:0] req, input logic rdy);
    @(negedge clk_i);
    req_i       = req;
    gnt_ready_i = rdy;
    @(posedge clk_i);
    model_step(req, rdy);
    #1;
    step_no++;
    $display("step %0d %s req=%h rdy=%b gnt=%h valid=%b", step_no, tag, req, rdy, gnt_o, gnt_valid_o);
    check_model(tag);
  endtask

  initial begin
    logic [N-1:0] rq;
    rst_ni      = 1'b0;
    req_i       = 8'hFF;
    gnt_ready_i = 1'b0;

    // 1. reset holds outputs low despite requests
    repeat (3) begin
      @(posedge clk_i);
      #1;
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_valid", 32'(gnt_valid_o), 32'd0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("rel", 8'hFF, 1'b0);
    chk("rel_lit", 32'(gnt_o), 32'h01);

    // 2. full request, always ready: 02,04,...,80,01
    for (int i = 1; i <= 9; i++) begin
      step("rot", 8'hFF, 1'b1);
      chk("rot_lit", 32'(gnt_o), 32'(8'h01 << (i % 8)));
    end

    // 3. two requesters alternate
    repeat (6) step("fair", 8'b1000_0100, 1'b1);

    // 4. sticky grant while not ready, then wrap to requester 0
    step("get04", 8'h04, 1'b1);
    chk("get04_lit", 32'(gnt_o), 32'h04);
    repeat (5) begin
      step("hold", 8'h01, 1'b0);
      chk("hold_lit", 32'(gnt_o), 32'h04);
    end
    step("wrap", 8'h01, 1'b1);
    chk("wrap_lit", 32'(gnt_o), 32'h01);
    step("idle", 8'h00, 1'b1);
    chk("idle_lit", 32'(gnt_valid_o), 32'd0);

    // 5. grant at top index wraps pointer to 0
    step("g80", 8'h80, 1'b0);
    chk("g80_lit", 32'(gnt_o), 32'h80);
    step("p0", 8'h81, 1'b1);
    chk("p0_lit", 32'(gnt_o), 32'h01);
    step("p1", 8'h81, 1'b1);
    chk("p1_lit", 32'(gnt_o), 32'h80);

    // 6. reset mid-grant
    step("g08", 8'h08, 1'b1);
    chk("g08_lit", 32'(gnt_o), 32'h08);
    step("h08", 8'h08, 1'b0);
    #2;
    rst_ni = 1'b0;
    m_g    = -1;
    m_ptr  = 0;
    #1;
    check_model("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("rel08", 8'h08, 1'b0);
    chk("rel08_lit", 32'(gnt_o), 32'h08);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rq = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rq = rq & 8'($urandom);
      if ($urandom_range(0, 7) == 0) rq = '0;
      step("rnd", rq, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
